scene_wr_arbiter: RTL
=====================

Name: scene_wr_arbiter

Overview:
- Sits between scene_loader and the SDRAM write port.
- Gives the loader's fire-and-forget write pulses (sl_we, one word per 4 XMODEM bytes; no back-pressure) a small elastic buffer.
- Arbitrates that stream against the frame-buffer/ray-core writer (fb_*) for the single valid/ready SDRAM write channel.
- Tracks scene load phase and tells the rest of the design when the scene in SDRAM is complete.

Parameters:
DEPTH, 8, entries in the loader write FIFO (power of 2, >=2)
ADDR_W, 25, SDRAM word address width
DATA_W, 32, SDRAM data width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sl_we  in  1  loader write strobe, one cycle per word
sl_addr  in  ADDR_W  loader write address, valid with sl_we
sl_io  in  DATA_W  loader write data, valid with sl_we
sl_done  in  1  loader transfer complete (level or pulse; rising edge used)
fb_req  in  1  FB writer request; addr/data held stable until fb_gnt
fb_addr  in  ADDR_W  FB write address
fb_data  in  DATA_W  FB write data
fb_gnt  out  1  FB word accepted this cycle
sdram_wr_valid  out  1  write request to SDRAM controller
sdram_wr_addr  out  ADDR_W  write address
sdram_wr_data  out  DATA_W  write data
sdram_wr_ready  in  1  controller accepts when valid&ready
scene_ready  out  1  scene fully written to SDRAM
sl_overflow  out  1  sticky: loader word dropped
sl_words  out  ADDR_W  loader words committed to SDRAM this load

Behaviour:
- Reset (rst low, async) values:
  - FSM=LOAD; FIFO empty; owner=NONE.
  - All outputs 0: fb_gnt, sdram_wr_valid, sdram_wr_addr, sdram_wr_data, scene_ready, sl_overflow, sl_words.
  - Reset mid-operation discards buffered words; no partial-write recovery.
- FIFO push: sl_we. Pop: an SL-owned transfer (valid&ready&owner==SL).
  - Push when full and no pop in the same cycle: word dropped, sl_overflow set. Cleared only by reset.
  - Push+pop when full: legal, occupancy unchanged, no overflow.
  - Push when empty: the word may be presented on sdram_wr_* the next cycle at earliest. No fall-through.
- Owner selection, evaluated only when owner==NONE or a transfer completes this cycle:
  - LOAD, DRAIN: SL if FIFO non-empty, else FB if fb_req, else NONE. FB may starve during a load; this is intended.
  - READY: FB if fb_req, else SL if FIFO non-empty.
- Owner is locked while sdram_wr_valid=1 and sdram_wr_ready=0. addr/data/valid stay stable until the handshake; the owner never switches mid-request.
- sdram_wr_valid = (owner!=NONE). sdram_wr_* are driven from the registered owner and the FIFO head or fb_*.
- fb_gnt = sdram_wr_valid & sdram_wr_ready & owner==FB. It is a combinational single-cycle pulse. Back-to-back transfers are allowed: 1 word/cycle when ready is held high.
- FSM (scene phase):
  - LOAD -> DRAIN on sl_done rising edge.
  - DRAIN -> READY when FIFO empty and no SL-owned request outstanding. scene_ready goes 1 in the cycle after that condition.
  - READY -> LOAD on any sl_we (scene reload). In the same cycle: scene_ready <= 0, sl_words <= 0. The sl_we word itself is still pushed.
  - sl_done edge while in DRAIN or READY: ignored.
- sl_words increments on each SL-owned transfer and wraps at 2^ADDR_W.

Decomposition:
- Shared package:
  - typedef enum {LOAD, DRAIN, READY} sl_phase_t
  - typedef enum {NONE, SL, FB} wr_owner_t
  - typedef struct packed {addr, data} sdram_wr_t
- One sub-module: sync_fifo. Parameterised width/depth, with push/pop/full/empty/head and a registered count.
- The arbiter FSM and owner lock stay in scene_wr_arbiter.

Test Plan:
- Reset, then 4 sl_we words to addr 0x0..0x3 with sdram_wr_ready=1 -> 4 SDRAM writes, in order, same data; sl_words=4; scene_ready=0.
- sdram_wr_ready=0 for 20 cycles, 9 sl_we pulses (DEPTH=8) -> sl_overflow=1. After ready is released: exactly 8 writes, first 8 words, no ninth.
- LOAD phase, fb_req held with FIFO non-empty -> no fb_gnt until FIFO empties. Then fb_gnt pulses once with fb_addr/fb_data on the bus.
- sl_done pulse with 3 words buffered, ready=1 -> scene_ready rises 1 cycle after the 3rd write; stays 1 with fb traffic.
- Owner lock: SL request stalled (ready=0), fb_req asserted mid-stall -> sdram_wr_addr unchanged until ready. SL completes first; FB follows.
- READY, then a new sl_we at addr 0x100 -> scene_ready=0 next cycle; sl_words=1 after the write; rst low mid-load -> all outputs 0 immediately.

Source files
------------

// File: rtl/scene_wr_arbiter_pkg.sv
// scene_wr_arbiter_pkg: shared types and the owner-selection rule for the scene write arbiter
package scene_wr_arbiter_pkg;
    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {LOAD, DRAIN, READY} sl_phase_t;
    typedef enum logic [1:0] {NONE, SL, FB} wr_owner_t;
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } sdram_wr_t;
    // Loader words win while a scene is loading or draining; once ready, FB traffic wins.
    function automatic wr_owner_t pick_owner(sl_phase_t ph, logic sl_av, logic fb_av);
        return (ph == READY) ? (fb_av ? FB : sl_av ? SL : NONE)
                             : (sl_av ? SL : fb_av ? FB : NONE);
    endfunction
endpackage

// File: rtl/scene_wr_arbiter_sync_fifo.sv
// sync_fifo: registered-head FIFO with a registered occupancy count
// Ports: clk, rst (async active-low), push/din write side, pop/head read side,
// full/empty/count status. A push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int W = 57,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] count_q, count_d;
    logic do_push, do_pop;
    always_comb begin
        full = count_q == (AW+1)'(DEPTH);
        empty = count_q == '0;
        do_pop = pop & ~empty;
        do_push = push & (~full | do_pop);
        wr_d = wr_q + AW'(do_push);
        rd_d = rd_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head = mem_q[rd_q];
        count = count_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
            count_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/scene_wr_arbiter.sv
// scene_wr_arbiter: buffers loader writes and arbitrates them against FB writes onto one SDRAM write channel
// Ports: clk, rst (async active-low); sl_we/sl_addr/sl_io/sl_done from the scene loader;
// fb_req/fb_addr/fb_data in, fb_gnt out for the FB writer; sdram_wr_valid/addr/data out and
// sdram_wr_ready in to the SDRAM controller; scene_ready, sl_overflow (sticky), sl_words status.
module scene_wr_arbiter
    import scene_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sl_we,
    input  logic [ADDR_W-1:0] sl_addr,
    input  logic [DATA_W-1:0] sl_io,
    input  logic              sl_done,
    input  logic              fb_req,
    input  logic [ADDR_W-1:0] fb_addr,
    input  logic [DATA_W-1:0] fb_data,
    output logic              fb_gnt,
    output logic              sdram_wr_valid,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [DATA_W-1:0] sdram_wr_data,
    input  logic              sdram_wr_ready,
    output logic              scene_ready,
    output logic              sl_overflow,
    output logic [ADDR_W-1:0] sl_words
);
    localparam int CW = $clog2(DEPTH) + 1;
    sl_phase_t phase_q, phase_d;
    wr_owner_t owner_q, owner_d;
    logic sl_done_q, scene_ready_q, scene_ready_d, sl_overflow_q, sl_overflow_d;
    logic [ADDR_W-1:0] sl_words_q, sl_words_d;
    sdram_wr_t sl_word, head, bus;
    logic full, empty;
    logic [CW-1:0] count;
    logic xfer, sl_pop, sl_av, fb_av, reload;
    assign sl_word = {sl_addr, sl_io};
    sync_fifo #(.W($bits(sdram_wr_t)), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(sl_we),
        .pop(sl_pop),
        .din(sl_word),
        .head(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= LOAD;
            owner_q <= NONE;
            sl_done_q <= 1'b0;
            scene_ready_q <= 1'b0;
            sl_overflow_q <= 1'b0;
            sl_words_q <= '0;
        end else begin
            phase_q <= phase_d;
            owner_q <= owner_d;
            sl_done_q <= sl_done;
            scene_ready_q <= scene_ready_d;
            sl_overflow_q <= sl_overflow_d;
            sl_words_q <= sl_words_d;
        end
    end
    // A completing transfer consumes the head entry or the current FB word, so neither
    // may be counted again when choosing the next owner in the same cycle.
    always_comb begin
        sl_av = count > CW'(sl_pop);
        fb_av = fb_req & ~fb_gnt;
        owner_d = (owner_q == NONE || xfer) ? pick_owner(phase_q, sl_av, fb_av) : owner_q;
        reload = (phase_q == READY) & sl_we;
        phase_d = (phase_q == LOAD && sl_done && !sl_done_q) ? DRAIN :
                  (phase_q == DRAIN && empty && owner_q != SL) ? READY :
                  reload ? LOAD : phase_q;
        scene_ready_d = phase_d == READY;
        sl_overflow_d = sl_overflow_q | (sl_we & full & ~sl_pop);
        sl_words_d = reload ? '0 : sl_words_q + ADDR_W'(sl_pop);
    end
    always_comb begin
        sdram_wr_valid = owner_q != NONE;
        xfer = sdram_wr_valid & sdram_wr_ready;
        sl_pop = xfer & (owner_q == SL);
        fb_gnt = xfer & (owner_q == FB);
        bus = (owner_q == SL) ? head : (owner_q == FB) ? {fb_addr, fb_data} : '0;
        sdram_wr_addr = bus.addr;
        sdram_wr_data = bus.data;
        scene_ready = scene_ready_q;
        sl_overflow = sl_overflow_q;
        sl_words = sl_words_q;
    end
endmodule
